// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX/ID operand forwarding, hazard stalls, mult/div scoreboard and stall counter
module fwd_hazard_unit #(
   parameter int REG_W   = 5,
   parameter int NUM_SRC = 2,
   parameter int MD_LAT  = 4,
   parameter int CNT_W   = 16
) (
   input  logic                     iCLK,
   input  logic                     iRST_n,
   input  logic [NUM_SRC*REG_W-1:0] iID_NumSrc,
   input  logic [NUM_SRC-1:0]       iID_UseSrc,
   input  logic                     iID_IsBranch,
   input  logic                     iID_IsMD,
   input  logic [NUM_SRC*REG_W-1:0] iEX_NumSrc,
   input  logic [REG_W-1:0]         iEX_NumRd,
   input  logic                     iEX_RegWrite,
   input  logic                     iEX_MemRead,
   input  logic [REG_W-1:0]         iMEM_NumRd,
   input  logic                     iMEM_RegWrite,
   input  logic [REG_W-1:0]         iWB_NumRd,
   input  logic                     iWB_RegWrite,
   input  logic                     iMD_Start,
   input  logic [REG_W-1:0]         iMD_NumRd,
   input  logic                     iClrCount,
   output logic [NUM_SRC*2-1:0]     oFwdEX,
   output logic [NUM_SRC*2-1:0]     oFwdID,
   output logic                     oStall,
   output logic                     oMD_Busy,
   output logic                     oMD_Done,
   output logic [CNT_W-1:0]         oStallCount
);

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

   // Four bits cover the largest reload value (MD_LAT - 2 = 14).
   localparam int               MD_CW   = 4;
   localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LAT - 2);

   md_state_e          state_q;
   logic [MD_CW-1:0]   md_cnt_q;
   logic [REG_W-1:0]   pend_rd_q;
   logic               busy_q;
   logic               done_q;
   logic [CNT_W-1:0]   stall_cnt_q;
   logic [CNT_W-1:0]   stall_cnt_d;

   logic [NUM_SRC*2-1:0] fwd_ex;
   logic [NUM_SRC*2-1:0] fwd_id;
   logic                 hit_ex_rd;
   logic                 hit_pend_rd;
   logic [REG_W-1:0]     ex_src;
   logic [REG_W-1:0]     id_src;

   logic load_use;
   logic branch_ex;
   logic md_raw;
   logic md_struct;
   logic stall;

   always_comb begin
      fwd_ex      = '0;
      fwd_id      = '0;
      hit_ex_rd   = 1'b0;
      hit_pend_rd = 1'b0;
      ex_src      = '0;
      id_src      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ex_src = iEX_NumSrc[i*REG_W +: REG_W];
         id_src = iID_NumSrc[i*REG_W +: REG_W];
         if (ex_src != '0) begin
            if (iMEM_RegWrite && (iMEM_NumRd == ex_src))
               fwd_ex[2*i +: 2] = 2'b10;
            else if (iWB_RegWrite && (iWB_NumRd == ex_src))
               fwd_ex[2*i +: 2] = 2'b01;
         end
         // Branch compare happens in ID, so ID forwarding only matters for branches.
         if (iID_IsBranch && (id_src != '0)) begin
            if (iMEM_RegWrite && (iMEM_NumRd == id_src))
               fwd_id[2*i +: 2] = 2'b10;
            else if (iWB_RegWrite && (iWB_NumRd == id_src))
               fwd_id[2*i +: 2] = 2'b01;
         end
         if (iID_UseSrc[i] && (id_src == iEX_NumRd))
            hit_ex_rd = 1'b1;
         if (iID_UseSrc[i] && (id_src == pend_rd_q))
            hit_pend_rd = 1'b1;
      end
   end

   assign load_use  = iEX_MemRead && (iEX_NumRd != '0) && hit_ex_rd;
   assign branch_ex = iID_IsBranch && iEX_RegWrite && (iEX_NumRd != '0) && hit_ex_rd;
   assign md_raw    = (state_q != MD_IDLE) && (pend_rd_q != '0) && hit_pend_rd;
   assign md_struct = iID_IsMD && (state_q != MD_IDLE);
   assign stall     = load_use || branch_ex || md_raw || md_struct;

   // Scoreboard: BUSY lasts MD_LAT-1 cycles, then DONE for one cycle.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q   <= MD_IDLE;
         md_cnt_q  <= '0;
         pend_rd_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            MD_IDLE: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (iMD_Start) begin
                  pend_rd_q <= iMD_NumRd;
                  md_cnt_q  <= MD_LOAD;
                  state_q   <= MD_BUSY;
                  busy_q    <= 1'b1;
               end
            end
            MD_BUSY: begin
               busy_q <= 1'b1;
               if (md_cnt_q == '0) begin
                  state_q <= MD_DONE;
                  done_q  <= 1'b1;
               end else begin
                  md_cnt_q <= md_cnt_q - 1'b1;
               end
            end
            MD_DONE: begin
               state_q   <= MD_IDLE;
               pend_rd_q <= '0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
            end
            default: begin
               state_q   <= MD_IDLE;
               pend_rd_q <= '0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (iClrCount)
         stall_cnt_d = '0;
      else if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

`ifndef SYNTHESIS
   always @(posedge iCLK) begin
      if (iRST_n)
         md_start_when_idle: assert (!(iMD_Start && (state_q != MD_IDLE)))
            else $warning("mult/div start ignored while scoreboard occupied");
   end
`endif

   assign oFwdEX      = fwd_ex;
   assign oFwdID      = fwd_id;
   assign oStall      = stall;
   assign oMD_Busy    = busy_q;
   assign oMD_Done    = done_q;
   assign oStallCount = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
   localparam int REG_W   = 5;
   localparam int NUM_SRC = 2;
   localparam int MD_LAT  = 4;
   localparam int CNT_W   = 6;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_SRC*REG_W-1:0] id_src;
   logic [NUM_SRC-1:0]       id_use;
   logic                     id_branch;
   logic                     id_md;
   logic [NUM_SRC*REG_W-1:0] ex_src;
   logic [REG_W-1:0]         ex_rd;
   logic                     ex_wr;
   logic                     ex_load;
   logic [REG_W-1:0]         mem_rd;
   logic                     mem_wr;
   logic [REG_W-1:0]         wb_rd;
   logic                     wb_wr;
   logic                     md_start;
   logic [REG_W-1:0]         md_rd;
   logic                     clr_cnt;
   logic [NUM_SRC*2-1:0]     fwd_ex;
   logic [NUM_SRC*2-1:0]     fwd_id;
   logic                     stall;
   logic                     md_busy;
   logic                     md_done;
   logic [CNT_W-1:0]         stall_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp;

   fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .iCLK(clk), .iRST_n(rst_n),
      .iID_NumSrc(id_src), .iID_UseSrc(id_use), .iID_IsBranch(id_branch), .iID_IsMD(id_md),
      .iEX_NumSrc(ex_src), .iEX_NumRd(ex_rd), .iEX_RegWrite(ex_wr), .iEX_MemRead(ex_load),
      .iMEM_NumRd(mem_rd), .iMEM_RegWrite(mem_wr), .iWB_NumRd(wb_rd), .iWB_RegWrite(wb_wr),
      .iMD_Start(md_start), .iMD_NumRd(md_rd), .iClrCount(clr_cnt),
      .oFwdEX(fwd_ex), .oFwdID(fwd_id), .oStall(stall), .oMD_Busy(md_busy),
      .oMD_Done(md_done), .oStallCount(stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle_inputs();
      id_src = '0; id_use = '0; id_branch = 1'b0; id_md = 1'b0;
      ex_src = '0; ex_rd = '0; ex_wr = 1'b0; ex_load = 1'b0;
      mem_rd = '0; mem_wr = 1'b0; wb_rd = '0; wb_wr = 1'b0;
      md_start = 1'b0; md_rd = '0; clr_cnt = 1'b0;
   endtask

   task automatic clear_count();
      @(posedge clk); #1;
      idle_inputs();
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      #13;
      exp = exp_q.pop_front(); checks++;
      if (32'(md_busy) !== exp) begin errors++; $display("FAIL reset_busy got %0h want %0h", md_busy, exp); end
      exp = exp_q.pop_front(); checks++;
      if (32'(md_done) !== exp) begin errors++; $display("FAIL reset_done got %0h want %0h", md_done, exp); end
      exp = exp_q.pop_front(); checks++;
      if (32'(stall_cnt) !== exp) begin errors++; $display("FAIL reset_count got %0h want %0h", stall_cnt, exp); end
      exp = exp_q.pop_front(); checks++;
      if (32'(stall) !== exp) begin errors++; $display("FAIL reset_stall got %0h want %0h", stall, exp); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fwd_ex();
      @(posedge clk); #1;
      idle_inputs();
      ex_src = {5'd5, 5'd8}; mem_rd = 5'd8; mem_wr = 1'b1; wb_rd = 5'd8; wb_wr = 1'b1;
      exp_q.push_back(32'b0010);
      #2; exp = exp_q.pop_front(); checks++;
      if (32'(fwd_ex) !== exp) begin errors++; $display("FAIL fwd_ex_mem_prio got %b want %b", fwd_ex, exp[3:0]); end
      mem_wr = 1'b0;
      exp_q.push_back(32'b0001);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(fwd_ex) !== exp) begin errors++; $display("FAIL fwd_ex_wb got %b want %b", fwd_ex, exp[3:0]); end
      mem_wr = 1'b1; wb_rd = 5'd5;
      exp_q.push_back(32'b0110);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(fwd_ex) !== exp) begin errors++; $display("FAIL fwd_ex_two_slots got %b want %b", fwd_ex, exp[3:0]); end
      ex_src = '0; mem_rd = '0; wb_rd = '0;
      exp_q.push_back(32'b0000);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(fwd_ex) !== exp) begin errors++; $display("FAIL fwd_ex_zero_reg got %b want %b", fwd_ex, exp[3:0]); end
   endtask

   task automatic test_fwd_id_branch();
      @(posedge clk); #1;
      idle_inputs();
      id_src = {5'd7, 5'd4}; id_use = 2'b11; mem_rd = 5'd7; mem_wr = 1'b1; wb_rd = 5'd4; wb_wr = 1'b1;
      exp_q.push_back(32'b0000);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(fwd_id) !== exp) begin errors++; $display("FAIL fwd_id_no_branch got %b want %b", fwd_id, exp[3:0]); end
      id_branch = 1'b1;
      exp_q.push_back(32'b1001);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(fwd_id) !== exp) begin errors++; $display("FAIL fwd_id_branch got %b want %b", fwd_id, exp[3:0]); end
      ex_rd = 5'd4; ex_wr = 1'b1;
      exp_q.push_back(32'd1);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(stall) !== exp) begin errors++; $display("FAIL branch_ex_stall got %0h want %0h", stall, exp); end
      id_branch = 1'b0;
      exp_q.push_back(32'd0);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(stall) !== exp) begin errors++; $display("FAIL branch_ex_nonbranch got %0h want %0h", stall, exp); end
   endtask

   task automatic test_load_use();
      clear_count();
      ex_rd = 5'd9; ex_load = 1'b1; id_src = {5'd9, 5'd2}; id_use = 2'b10;
      exp_q.push_back(32'd1);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(stall) !== exp) begin errors++; $display("FAIL load_use_stall got %0h want %0h", stall, exp); end
      exp_q.push_back(32'd1);
      @(posedge clk); #1;
      exp = exp_q.pop_front(); checks++;
      if (32'(stall_cnt) !== exp) begin errors++; $display("FAIL load_use_count got %0h want %0h", stall_cnt, exp); end
      id_use = 2'b01;
      exp_q.push_back(32'd0);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(stall) !== exp) begin errors++; $display("FAIL load_use_unused got %0h want %0h", stall, exp); end
      ex_rd = 5'd0; id_src = '0; id_use = 2'b11;
      exp_q.push_back(32'd0);
      #1; exp = exp_q.pop_front(); checks++;
      if (32'(stall) !== exp) begin errors++; $display("FAIL load_use_r0 got %0h want %0h", stall, exp); end
   endtask

   task automatic test_md_raw();
      @(posedge clk); #1;
      idle_inputs();
      md_start = 1'b1; md_rd = 5'd12; id_src = {5'd0, 5'd12}; id_use = 2'b01;
      @(posedge clk); #1;
      md_start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         exp_q.push_back({29'd0, (k <= 4), (k == 4), (k <= 4)});
         exp = exp_q.pop_front(); checks++;
         if ({29'd0, md_busy, md_done, stall} !== exp)
            begin errors++; $display("FAIL md_raw_cycle%0d busy/done/stall got %b%b%b want %b", k, md_busy, md_done, stall, exp[2:0]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_md_structural();
      @(posedge clk); #1;
      idle_inputs();
      md_start = 1'b1; md_rd = 5'd3;
      @(posedge clk); #1;
      md_start = 1'b0; id_md = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         md_start = (k == 2); md_rd = 5'd7;
         exp_q.push_back({29'd0, (k <= 4), (k == 4), (k <= 4)});
         #1; exp = exp_q.pop_front(); checks++;
         if ({29'd0, md_busy, md_done, stall} !== exp)
            begin errors++; $display("FAIL md_struct_cycle%0d busy/done/stall got %b%b%b want %b", k, md_busy, md_done, stall, exp[2:0]); end
         @(posedge clk); #1;
      end
      md_start = 1'b0; id_md = 1'b0;
   endtask

   task automatic test_async_reset();
      clear_count();
      md_start = 1'b1; md_rd = 5'd12; id_src = {5'd12, 5'd0}; id_use = 2'b10;
      @(posedge clk); #1;
      md_start = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      exp_q.push_back(32'd0);
      #1; exp = exp_q.pop_front(); checks++;
      if ({31'd0, md_busy} !== exp) begin errors++; $display("FAIL async_rst_busy got %0h want %0h", md_busy, exp); end
      exp_q.push_back(32'd0);
      exp = exp_q.pop_front(); checks++;
      if (32'(stall_cnt) !== exp) begin errors++; $display("FAIL async_rst_count got %0h want %0h", stall_cnt, exp); end
      #3; rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         exp_q.push_back(32'd0);
         exp = exp_q.pop_front(); checks++;
         if ({30'd0, stall, md_done} !== exp) begin errors++; $display("FAIL async_rst_after%0d stall/done got %b%b want 00", k, stall, md_done); end
      end
   endtask

   task automatic test_saturation();
      clear_count();
      ex_rd = 5'd9; ex_load = 1'b1; id_src = {5'd9, 5'd9}; id_use = 2'b11;
      repeat ((1 << CNT_W) + 5) @(posedge clk);
      #1;
      exp_q.push_back(32'((1 << CNT_W) - 1));
      exp = exp_q.pop_front(); checks++;
      if (32'(stall_cnt) !== exp) begin errors++; $display("FAIL sat_count got %0h want %0h", stall_cnt, exp); end
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      exp_q.push_back(32'd0);
      exp = exp_q.pop_front(); checks++;
      if (32'(stall_cnt) !== exp) begin errors++; $display("FAIL clr_with_stall got %0h want %0h", stall_cnt, exp); end
      @(posedge clk); #1;
      exp_q.push_back(32'd1);
      exp = exp_q.pop_front(); checks++;
      if (32'(stall_cnt) !== exp) begin errors++; $display("FAIL count_after_clr got %0h want %0h", stall_cnt, exp); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_fwd_ex();
      test_fwd_id_branch();
      test_load_use();
      test_md_raw();
      test_md_structural();
      test_async_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding logic for the 5-stage MIPS core.
- Generates per-source forwarding selects for EX (ALU operands) and ID (branch compare).
- Also owns hazard detection: load-use stall, branch-on-EX-result stall, and a scoreboard FSM for the multi-cycle multiply/divide unit.
- A saturating stall-cycle counter provides performance monitoring.
- Sits beside the hazard/control path and drives the operand muxes and the PC/IF-ID write-enables.

Parameters:
- REG_W, 5, register-number width.
- NUM_SRC, 2, number of source operands per instruction; legal range 1..4.
- MD_LAT, 4, mult/div latency in cycles from start to result write; legal range 2..16.
- CNT_W, 16, stall-counter width.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST_n  in  1  reset, asynchronous, active-low.
- iID_NumSrc  in  NUM_SRC*REG_W  ID source register numbers; slot i at bits [i*REG_W +: REG_W].
- iID_UseSrc  in  NUM_SRC  slot i is actually read by the ID instruction.
- iID_IsBranch  in  1  ID instruction compares operands in ID.
- iID_IsMD  in  1  ID instruction is a mult/div.
- iEX_NumSrc  in  NUM_SRC*REG_W  EX source register numbers.
- iEX_NumRd  in  REG_W  EX destination register.
- iEX_RegWrite  in  1  EX instruction writes the register file.
- iEX_MemRead  in  1  EX instruction is a load.
- iMEM_NumRd  in  REG_W  MEM destination register.
- iMEM_RegWrite  in  1  MEM instruction writes the register file.
- iWB_NumRd  in  REG_W  WB destination register.
- iWB_RegWrite  in  1  WB instruction writes the register file.
- iMD_Start  in  1  mult/div issues from EX this cycle.
- iMD_NumRd  in  REG_W  mult/div destination register.
- iClrCount  in  1  synchronous clear of the stall counter.
- oFwdEX  out  NUM_SRC*2  per-slot EX mux select: 10 = MEM->EX, 01 = WB->EX, 00 = none.
- oFwdID  out  NUM_SRC*2  per-slot ID branch mux select, same encoding.
- oStall  out  1  freeze PC and IF/ID; bubble into ID/EX.
- oMD_Busy  out  1  scoreboard holds a pending mult/div.
- oMD_Done  out  1  mult/div result is written this cycle.
- oStallCount  out  CNT_W  saturating count of cycles with oStall = 1.

Behaviour:
- Reset (iRST_n = 0, asynchronous): FSM = IDLE, down-counter = 0, pending rd = 0, oStallCount = 0, oMD_Busy = 0, oMD_Done = 0.
- oFwdEX / oFwdID / oStall are purely combinational from inputs and registered state. During reset they evaluate with state at its reset values.

EX forwarding, per slot i (s = EX source register):
- s == 0 -> 00.
- else if iMEM_RegWrite && iMEM_NumRd == s -> 10. MEM has priority over WB.
- else if iWB_RegWrite && iWB_NumRd == s -> 01.
- else -> 00.

ID forwarding, per slot:
- Same rules using iID_NumSrc.
- Forced to 00 when iID_IsBranch = 0.

Stall conditions (oStall = OR of all):
- Load-use: iEX_MemRead && iEX_NumRd != 0 && some slot has iID_UseSrc = 1 and matches iEX_NumRd.
- Branch-on-EX: iID_IsBranch && iEX_RegWrite && iEX_NumRd != 0 && a used ID slot matches iEX_NumRd.
- MD RAW: FSM in BUSY or DONE && pending rd != 0 && a used ID slot matches pending rd.
- MD structural: iID_IsMD && FSM != IDLE.

Mult/div scoreboard FSM:
- IDLE: on iMD_Start, latch pending rd = iMD_NumRd, load counter = MD_LAT - 2, go to BUSY.
- BUSY: oMD_Busy = 1. If counter == 0, go to DONE; otherwise decrement.
- DONE: oMD_Busy = 1, oMD_Done = 1 for exactly one cycle. Go to IDLE, clearing pending rd.
- Start-to-Done latency: oMD_Done is high MD_LAT cycles after the iMD_Start edge.
- The RAW stall holds through DONE. The register file write occurs at the end of DONE, so the consumer reads the new value in the following cycle.
- iMD_Start while not IDLE is a protocol violation (prevented by the structural stall). It is ignored, and a simulation-only assertion fires.
- A mult/div to $0 runs the FSM normally but never causes a RAW stall.

Stall counter:
- Increments each cycle with oStall = 1.
- Saturates at all-ones; no wrap.
- iClrCount has priority over increment; the count is 0 on the next edge.

Test Plan:
- EX slot0 = 8, MEM RegWrite rd = 8, WB RegWrite rd = 8 -> oFwdEX[1:0] = 10. Same with MEM RegWrite = 0 -> 01. EX src = 0 with matching rd = 0 -> 00.
- EX = lw rd 9; ID uses slot1 = 9 -> oStall = 1 and oStallCount increments by 1. With iID_UseSrc[1] = 0 -> oStall = 0.
- MD_LAT = 4: iMD_Start rd = 12 at cycle 0 -> oMD_Busy high cycles 1..4, oMD_Done high in cycle 4 only. An ID instruction reading 12 stalls cycles 1..4 and proceeds in cycle 5.
- iID_IsMD = 1 during BUSY -> oStall = 1 until FSM returns to IDLE. A second iMD_Start forced in BUSY -> state unchanged, assertion fires.
- Assert iRST_n low mid-BUSY (asynchronously, off-edge) -> oMD_Busy = 0 and oStallCount = 0 immediately, with no pending RAW stall afterwards.
- Hold stall conditions for 2^CNT_W + 5 cycles -> oStallCount saturates at all-ones. iClrCount together with a stall -> count = 0.
